// File: rtl/decoder.sv
// 8B/10B receive code-group decoder with running-disparity tracking for the 1000BASE-X PCS.
// Define DECODER_ERR_CNT_EN to add the saturating err_cnt output and its register.
module decoder (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       rx_valid,
    input  logic [9:0] rx_code_group,
    output logic       dec_valid,
    output logic [7:0] rx_o_set,
    output logic       rx_k,
    output logic       rx_comma,
    output logic       rx_cv,
    output logic       rx_rd_err,
`ifdef DECODER_ERR_CNT_EN
    output logic       rx_rd,
    output logic [7:0] err_cnt
`else
    output logic       rx_rd
`endif
);

    localparam logic [5:0] K28_NEG = 6'b001111;
    localparam logic [5:0] K28_POS = 6'b110000;

    function automatic logic rd_after_six(input logic rd, input logic [5:0] s);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 6; i++) ones = ones + {2'b00, s[i]};
        if (s == 6'b000111) return 1'b1;
        if (s == 6'b111000) return 1'b0;
        if (ones > 3'd3) return 1'b1;
        if (ones < 3'd3) return 1'b0;
        return rd;
    endfunction

    function automatic logic rd_after_four(input logic rd, input logic [3:0] f);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 4; i++) ones = ones + {2'b00, f[i]};
        if (f == 4'b0011) return 1'b1;
        if (f == 4'b1100) return 1'b0;
        if (ones > 3'd2) return 1'b1;
        if (ones < 3'd2) return 1'b0;
        return rd;
    endfunction

    // K28 fghj in the form that follows 001111; returns {found, y}
    function automatic logic [3:0] k28_lookup(input logic [3:0] f);
        logic [3:0] r;
        case (f)
            4'b0100: r = 4'b1000;
            4'b1001: r = 4'b1001;
            4'b0101: r = 4'b1010;
            4'b0011: r = 4'b1011;
            4'b0010: r = 4'b1100;
            4'b1010: r = 4'b1101;
            4'b0110: r = 4'b1110;
            4'b1000: r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [5:0] six_b;
    logic [3:0] four_b;
    assign six_b  = rx_code_group[9:4];
    assign four_b = rx_code_group[3:0];

    // 5b/6b table: {in RD- column, in RD+ column, EDCBA}
    logic       six_in_m;
    logic       six_in_p;
    logic [4:0] six_val;

    always_comb begin
        {six_in_m, six_in_p, six_val} = 7'd0;
        case (six_b)
            6'b100111: {six_in_m, six_in_p, six_val} = {2'b10, 5'd0};
            6'b011000: {six_in_m, six_in_p, six_val} = {2'b01, 5'd0};
            6'b011101: {six_in_m, six_in_p, six_val} = {2'b10, 5'd1};
            6'b100010: {six_in_m, six_in_p, six_val} = {2'b01, 5'd1};
            6'b101101: {six_in_m, six_in_p, six_val} = {2'b10, 5'd2};
            6'b010010: {six_in_m, six_in_p, six_val} = {2'b01, 5'd2};
            6'b110001: {six_in_m, six_in_p, six_val} = {2'b11, 5'd3};
            6'b110101: {six_in_m, six_in_p, six_val} = {2'b10, 5'd4};
            6'b001010: {six_in_m, six_in_p, six_val} = {2'b01, 5'd4};
            6'b101001: {six_in_m, six_in_p, six_val} = {2'b11, 5'd5};
            6'b011001: {six_in_m, six_in_p, six_val} = {2'b11, 5'd6};
            6'b111000: {six_in_m, six_in_p, six_val} = {2'b10, 5'd7};
            6'b000111: {six_in_m, six_in_p, six_val} = {2'b01, 5'd7};
            6'b111001: {six_in_m, six_in_p, six_val} = {2'b10, 5'd8};
            6'b000110: {six_in_m, six_in_p, six_val} = {2'b01, 5'd8};
            6'b100101: {six_in_m, six_in_p, six_val} = {2'b11, 5'd9};
            6'b010101: {six_in_m, six_in_p, six_val} = {2'b11, 5'd10};
            6'b110100: {six_in_m, six_in_p, six_val} = {2'b11, 5'd11};
            6'b001101: {six_in_m, six_in_p, six_val} = {2'b11, 5'd12};
            6'b101100: {six_in_m, six_in_p, six_val} = {2'b11, 5'd13};
            6'b011100: {six_in_m, six_in_p, six_val} = {2'b11, 5'd14};
            6'b010111: {six_in_m, six_in_p, six_val} = {2'b10, 5'd15};
            6'b101000: {six_in_m, six_in_p, six_val} = {2'b01, 5'd15};
            6'b011011: {six_in_m, six_in_p, six_val} = {2'b10, 5'd16};
            6'b100100: {six_in_m, six_in_p, six_val} = {2'b01, 5'd16};
            6'b100011: {six_in_m, six_in_p, six_val} = {2'b11, 5'd17};
            6'b010011: {six_in_m, six_in_p, six_val} = {2'b11, 5'd18};
            6'b110010: {six_in_m, six_in_p, six_val} = {2'b11, 5'd19};
            6'b001011: {six_in_m, six_in_p, six_val} = {2'b11, 5'd20};
            6'b101010: {six_in_m, six_in_p, six_val} = {2'b11, 5'd21};
            6'b011010: {six_in_m, six_in_p, six_val} = {2'b11, 5'd22};
            6'b111010: {six_in_m, six_in_p, six_val} = {2'b10, 5'd23};
            6'b000101: {six_in_m, six_in_p, six_val} = {2'b01, 5'd23};
            6'b110011: {six_in_m, six_in_p, six_val} = {2'b10, 5'd24};
            6'b001100: {six_in_m, six_in_p, six_val} = {2'b01, 5'd24};
            6'b100110: {six_in_m, six_in_p, six_val} = {2'b11, 5'd25};
            6'b010110: {six_in_m, six_in_p, six_val} = {2'b11, 5'd26};
            6'b110110: {six_in_m, six_in_p, six_val} = {2'b10, 5'd27};
            6'b001001: {six_in_m, six_in_p, six_val} = {2'b01, 5'd27};
            6'b001110: {six_in_m, six_in_p, six_val} = {2'b11, 5'd28};
            6'b101110: {six_in_m, six_in_p, six_val} = {2'b10, 5'd29};
            6'b010001: {six_in_m, six_in_p, six_val} = {2'b01, 5'd29};
            6'b011110: {six_in_m, six_in_p, six_val} = {2'b10, 5'd30};
            6'b100001: {six_in_m, six_in_p, six_val} = {2'b01, 5'd30};
            6'b101011: {six_in_m, six_in_p, six_val} = {2'b10, 5'd31};
            6'b010100: {six_in_m, six_in_p, six_val} = {2'b01, 5'd31};
            K28_NEG:   {six_in_m, six_in_p, six_val} = {2'b10, 5'd28};
            K28_POS:   {six_in_m, six_in_p, six_val} = {2'b01, 5'd28};
            default:   {six_in_m, six_in_p, six_val} = 7'd0;
        endcase
    end

    // 3b/4b data table: {in RD- column, in RD+ column, alternate D.x.7 form, HGF}
    logic       four_in_m;
    logic       four_in_p;
    logic       four_alt;
    logic [2:0] four_val;

    always_comb begin
        {four_in_m, four_in_p, four_alt, four_val} = 6'd0;
        case (four_b)
            4'b1011: {four_in_m, four_in_p, four_alt, four_val} = {3'b100, 3'd0};
            4'b0100: {four_in_m, four_in_p, four_alt, four_val} = {3'b010, 3'd0};
            4'b1001: {four_in_m, four_in_p, four_alt, four_val} = {3'b110, 3'd1};
            4'b0101: {four_in_m, four_in_p, four_alt, four_val} = {3'b110, 3'd2};
            4'b1100: {four_in_m, four_in_p, four_alt, four_val} = {3'b100, 3'd3};
            4'b0011: {four_in_m, four_in_p, four_alt, four_val} = {3'b010, 3'd3};
            4'b1101: {four_in_m, four_in_p, four_alt, four_val} = {3'b100, 3'd4};
            4'b0010: {four_in_m, four_in_p, four_alt, four_val} = {3'b010, 3'd4};
            4'b1010: {four_in_m, four_in_p, four_alt, four_val} = {3'b110, 3'd5};
            4'b0110: {four_in_m, four_in_p, four_alt, four_val} = {3'b110, 3'd6};
            4'b1110: {four_in_m, four_in_p, four_alt, four_val} = {3'b100, 3'd7};
            4'b0001: {four_in_m, four_in_p, four_alt, four_val} = {3'b010, 3'd7};
            4'b0111: {four_in_m, four_in_p, four_alt, four_val} = {3'b101, 3'd7};
            4'b1000: {four_in_m, four_in_p, four_alt, four_val} = {3'b011, 3'd7};
            default: {four_in_m, four_in_p, four_alt, four_val} = 6'd0;
        endcase
    end

    logic       rd_six;
    logic       rd_next;
    logic       is_k28;
    logic [3:0] k_eff;
    logic [3:0] k_own;
    logic [3:0] k_oth;
    logic       six_ok;
    logic       six_any;
    logic       four_ok;
    logic       four_any;
    logic [2:0] hgf;
    logic       cv_d;
    logic       rd_err_d;
    logic       k_d;
    logic       comma_d;
    logic [7:0] oset_d;

    always_comb begin
        rd_six   = rd_after_six(rx_rd, six_b);
        rd_next  = rd_after_four(rd_six, four_b);
        is_k28   = (six_b == K28_NEG) || (six_b == K28_POS);
        // After 110000 the K28 fghj is the complement of the 001111 form
        k_eff    = (six_b == K28_POS) ? ~four_b : four_b;
        k_own    = k28_lookup(k_eff);
        k_oth    = k28_lookup(~k_eff);
        six_ok   = rx_rd ? six_in_p : six_in_m;
        six_any  = six_in_m | six_in_p;
        four_ok  = 1'b0;
        four_any = 1'b0;
        hgf      = 3'd0;
        if (is_k28) begin
            four_ok  = k_own[3];
            four_any = k_own[3] | k_oth[3];
            hgf      = k_own[3] ? k_own[2:0] : k_oth[2:0];
        end else begin
            four_ok  = rd_six ? four_in_p : four_in_m;
            four_any = four_in_m | four_in_p;
            hgf      = four_val;
        end
        cv_d     = !(six_any && four_any);
        rd_err_d = !cv_d && !(six_ok && four_ok);
        k_d      = !cv_d && (is_k28 || (four_alt && (six_val == 5'd23 || six_val == 5'd27 ||
                                                      six_val == 5'd29 || six_val == 5'd30)));
        oset_d   = cv_d ? 8'h00 : {hgf, six_val};
        comma_d  = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            dec_valid <= 1'b0;
            rx_o_set  <= 8'h00;
            rx_k      <= 1'b0;
            rx_comma  <= 1'b0;
            rx_cv     <= 1'b0;
            rx_rd_err <= 1'b0;
            rx_rd     <= 1'b0;
        end else begin
            dec_valid <= rx_valid;
            if (rx_valid) begin
                rx_o_set  <= oset_d;
                rx_k      <= k_d;
                rx_comma  <= comma_d;
                rx_cv     <= cv_d;
                rx_rd_err <= rd_err_d;
                rx_rd     <= rd_next;
            end
        end
    end

`ifdef DECODER_ERR_CNT_EN
    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            err_cnt <= 8'd0;
        end else if (rx_valid && (cv_d || rd_err_d) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder.sv
// Randomized self-checking bench for decoder against a table-driven 8B/10B reference model.
// Error-counter checks are compiled in when DECODER_ERR_CNT_EN is defined.
module tb_decoder;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset;
    logic       rx_valid;
    logic [9:0] rx_code_group;
    logic       dec_valid;
    logic [7:0] rx_o_set;
    logic       rx_k;
    logic       rx_comma;
    logic       rx_cv;
    logic       rx_rd_err;
    logic       rx_rd;
`ifdef DECODER_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 GTX_CLK = ~GTX_CLK;

    decoder dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .rx_valid      (rx_valid),
        .rx_code_group (rx_code_group),
        .dec_valid     (dec_valid),
        .rx_o_set      (rx_o_set),
        .rx_k          (rx_k),
        .rx_comma      (rx_comma),
        .rx_cv         (rx_cv),
        .rx_rd_err     (rx_rd_err),
`ifdef DECODER_ERR_CNT_EN
        .rx_rd         (rx_rd),
        .err_cnt       (err_cnt)
`else
        .rx_rd         (rx_rd)
`endif
    );

    // Encoder tables indexed by x (5b) or y (3b): code emitted at RD- and at RD+
    localparam logic [5:0] SIX_M [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] SIX_P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] FOUR_M [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                          4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] FOUR_P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                          4'b0010, 4'b1010, 4'b0110, 4'b0001};
    localparam logic [3:0] K28_F [8]  = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                          4'b0010, 4'b1010, 4'b0110, 4'b1000};
    localparam logic [5:0] K28_M = 6'b001111;
    localparam logic [5:0] K28_P = 6'b110000;

    logic       m_rd, m_dv, m_k, m_comma, m_cv, m_rderr;
    logic [7:0] m_oct;
    int         m_cnt;

    function automatic logic rd6_of(input logic rd, input logic [5:0] s);
        int ones = $countones(s);
        if (ones > 3 || s == 6'b000111) return 1'b1;
        if (ones < 3 || s == 6'b111000) return 1'b0;
        return rd;
    endfunction

    function automatic logic rd4_of(input logic rd, input logic [3:0] f);
        int ones = $countones(f);
        if (ones > 2 || f == 4'b0011) return 1'b1;
        if (ones < 2 || f == 4'b1100) return 1'b0;
        return rd;
    endfunction

    function automatic logic [13:0] dut_vec();
        return {dec_valid, rx_o_set, rx_k, rx_comma, rx_cv, rx_rd_err, rx_rd};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_dv, m_oct, m_k, m_comma, m_cv, m_rderr, m_rd};
    endfunction

    task automatic model_reset();
        {m_rd, m_dv, m_k, m_comma, m_cv, m_rderr} = 6'd0;
        m_oct = 8'h00;
        m_cnt = 0;
    endtask

    task automatic model_group(input logic [9:0] cg);
        logic [5:0] s;
        logic [3:0] f;
        logic       in_m6, in_p6, in_m4, in_p4, alt, is_k28, own4, oth4, own6, rd6, cv, rderr;
        logic [3:0] kf [8];
        int         x, y;
        s = cg[9:4];
        f = cg[3:0];
        {in_m6, in_p6, in_m4, in_p4, alt, own4, oth4} = 7'd0;
        x = 0;
        y = 0;
        for (int i = 0; i < 32; i++) begin
            if (SIX_M[i] == s) begin in_m6 = 1'b1; x = i; end
            if (SIX_P[i] == s) begin in_p6 = 1'b1; x = i; end
        end
        is_k28 = (s == K28_M) || (s == K28_P);
        if (s == K28_M) begin in_m6 = 1'b1; x = 28; end
        if (s == K28_P) begin in_p6 = 1'b1; x = 28; end
        rd6 = rd6_of(m_rd, s);
        if (is_k28) begin
            for (int i = 0; i < 8; i++) kf[i] = (s == K28_M) ? K28_F[i] : ~K28_F[i];
            for (int i = 0; i < 8; i++) if (kf[i] == f) begin own4 = 1'b1; y = i; end
            if (!own4)
                for (int i = 0; i < 8; i++) if (~kf[i] == f) begin oth4 = 1'b1; y = i; end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (FOUR_M[i] == f) begin in_m4 = 1'b1; y = i; end
                if (FOUR_P[i] == f) begin in_p4 = 1'b1; y = i; end
            end
            if (f == 4'b0111) begin in_m4 = 1'b1; y = 7; alt = 1'b1; end
            if (f == 4'b1000) begin in_p4 = 1'b1; y = 7; alt = 1'b1; end
            own4 = rd6 ? in_p4 : in_m4;
            oth4 = rd6 ? in_m4 : in_p4;
        end
        own6    = m_rd ? in_p6 : in_m6;
        cv      = !(in_m6 || in_p6) || !(own4 || oth4);
        rderr   = !cv && (!own6 || !own4);
        m_cv    = cv;
        m_rderr = rderr;
        m_oct   = cv ? 8'h00 : {y[2:0], x[4:0]};
        m_k     = !cv && (is_k28 || (alt && (x inside {23, 27, 29, 30})));
        m_comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
        m_rd    = rd4_of(rd6, f);
        if ((cv || rderr) && m_cnt < 255) m_cnt++;
    endtask

    // Present one cycle of input, update the model at the sampling edge, settle 1 time unit
    task automatic drive(input logic v, input logic [9:0] cg);
        rx_valid      = v;
        rx_code_group = cg;
        @(posedge GTX_CLK);
        if (v) model_group(cg);
        m_dv = v;
        #1;
        rx_valid      = 1'b0;
        rx_code_group = 10'($urandom);
    endtask

    task automatic test_reset();
        mr_main_reset = 1'b0;
        rx_valid      = 1'b0;
        rx_code_group = 10'd0;
        repeat (3) @(posedge GTX_CLK);
        #1;
        vectors++;
        if (dut_vec() !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 14'd0);
        end
`ifdef DECODER_ERR_CNT_EN
        vectors++;
        if (err_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        mr_main_reset = 1'b1;
        model_reset();
    endtask

    task automatic test_directed();
        logic [9:0]  cgs  [5] = '{10'b1010101010, 10'b0011111010, 10'b1100000101,
                                  10'b1100000101, 10'b0000000000};
        // {dec_valid, octet, k, comma, cv, rd_err, rd}
        logic [13:0] want [5] = '{{1'b1, 8'hB5, 5'b00000}, {1'b1, 8'hBC, 5'b11001},
                                  {1'b1, 8'hBC, 5'b11000}, {1'b1, 8'hBC, 5'b11010},
                                  {1'b1, 8'h00, 5'b00100}};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, cgs[i]);
            vectors++;
            if (dut_vec() !== want[i]) begin
                miscompares++;
                $display("FAIL directed_%0d: got %h want %h", i, dut_vec(), want[i]);
            end
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL directed_model_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
`ifdef DECODER_ERR_CNT_EN
            if (i == 3) begin
                vectors++;
                if (err_cnt !== 8'd1) begin
                    miscompares++;
                    $display("FAIL directed_err_cnt: got %0d want 1", err_cnt);
                end
            end
`endif
        end
    endtask

    task automatic test_gaps();
        logic       vs  [12] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
        logic [9:0] cgs [12];
        cgs[0] = 10'b0011111010;
        cgs[1] = 10'b1100000101;
        for (int i = 2; i < 12; i++) cgs[i] = 10'b1001110100;
        for (int i = 0; i < 12; i++) begin
            drive(vs[i], vs[i] ? cgs[i] : 10'($urandom));
            vectors++;
            if (dec_valid !== vs[i]) begin
                miscompares++;
                $display("FAIL gap_dec_valid_%0d: got %b want %b", i, dec_valid, vs[i]);
            end
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL gap_hold_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_midstream_reset();
        drive(1'b1, 10'b0011111010);
        vectors++;
        if (rx_rd !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_rd: got %b want 1", rx_rd);
        end
        mr_main_reset = 1'b0;
        #2;
        vectors++;
        if (dut_vec() !== 14'd0) begin
            miscompares++;
            $display("FAIL midstream_reset: got %h want %h", dut_vec(), 14'd0);
        end
        @(posedge GTX_CLK);
        #1;
        mr_main_reset = 1'b1;
        model_reset();
        drive(1'b1, 10'b1100000101);
        vectors++;
        if (dut_vec() !== {1'b1, 8'hBC, 5'b11010}) begin
            miscompares++;
            $display("FAIL first_after_reset: got %h want %h", dut_vec(), {1'b1, 8'hBC, 5'b11010});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            logic       v;
            logic       rd_e;
            logic       rd6;
            logic [5:0] s;
            logic [3:0] f;
            int         sel, x, y;
            sel  = $urandom_range(0, 9);
            x    = $urandom_range(0, 31);
            y    = $urandom_range(0, 7);
            rd_e = ($urandom_range(0, 4) == 0) ? !m_rd : m_rd;
            v    = ($urandom_range(0, 3) != 0);
            if (sel <= 5) begin
                s   = rd_e ? SIX_P[x] : SIX_M[x];
                rd6 = rd6_of(rd_e, s);
                f   = rd6 ? FOUR_P[y] : FOUR_M[y];
                if (y == 7 && $urandom_range(0, 1) == 1) f = rd6 ? 4'b1000 : 4'b0111;
            end else if (sel == 6) begin
                s = rd_e ? K28_P : K28_M;
                f = (s == K28_M) ? K28_F[y] : ~K28_F[y];
            end else begin
                {s, f} = 10'($urandom);
            end
            drive(v, {s, f});
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: cg %b got %h want %h", n, {s, f}, dut_vec(), exp_vec());
            end
`ifdef DECODER_ERR_CNT_EN
            vectors++;
            if (err_cnt !== 8'(m_cnt)) begin
                miscompares++;
                $display("FAIL random_err_cnt_%0d: got %0d want %0d", n, err_cnt, m_cnt);
            end
`endif
        end
    endtask

`ifdef DECODER_ERR_CNT_EN
    task automatic test_err_cnt_saturate();
        mr_main_reset = 1'b0;
        #2;
        mr_main_reset = 1'b1;
        model_reset();
        for (int i = 0; i < 300; i++) drive(1'b1, 10'b0000000000);
        vectors++;
        if (err_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL err_cnt_saturate: got %0d want 255", err_cnt);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_directed();
        test_gaps();
        test_midstream_reset();
        test_random();
`ifdef DECODER_ERR_CNT_EN
        test_err_cnt_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder.md
# decoder

Receive-side 8B/10B code-group decoder for the 1000BASE-X PCS. It is the counterpart of the transmit encoder, which maps ordered-set octets onto 10-bit code-groups.
- Takes one 10-bit code-group per qualified cycle and tracks running disparity.
- Returns the octet, a control (K) flag, a comma flag, and code-violation and disparity-error flags, one cycle later.
- Sits between the deserializer/synchronization logic and the PCS receive state machine.

## Interface
Parameters:
- none

Ports:
- GTX_CLK  input  1  PCS clock; all state changes on the rising edge.
- mr_main_reset  input  1  asynchronous, active-low reset.
- rx_valid  input  1  qualifies rx_code_group this cycle.
- rx_code_group  input  10  code-group. Bit 9 = a (first on the line), then b,c,d,e,i,f,g,h; bit 0 = j.
- dec_valid  output  1  one-cycle strobe: decoded outputs updated this cycle.
- rx_o_set  output  8  decoded octet HGFEDCBA (bit 7 = H).
- rx_k  output  1  code-group is a valid special (K) code-group.
- rx_comma  output  1  bits a..g equal 0011111 or 1100000.
- rx_cv  output  1  code violation: group found in neither disparity column.
- rx_rd_err  output  1  group valid only in the column of the opposite running disparity.
- rx_rd  output  1  current running disparity (0 = negative, 1 = positive).
- err_cnt  output  8  saturating error count; present only with DECODER_ERR_CNT_EN.

## Operation
- Running disparity (RD) register:
  - reset value negative;
  - evaluated per sub-block, 6b (abcdei) first, then 4b (fghj);
  - sub-block with more ones → RD positive; more zeros → RD negative;
  - neutral 000111 or 0011 → positive; neutral 111000 or 1100 → negative; any other neutral sub-block leaves RD unchanged;
  - RD is always updated from the received bits, including on rx_cv or rx_rd_err.
- Data: every D.x.y is accepted. For D.x.7, both primary (1110/0001) and alternate (0111/1000) fghj are accepted without error.
- Control: K28.0–K28.7, K23.7, K27.7, K29.7 and K30.7 give rx_k=1. K.x.7 requires the alternate-form fghj.
- Sub-block validity:
  - abcdei must appear in the 5b/6b table for the RD entering the group;
  - fghj must appear in the 3b/4b table for the RD after the 6b sub-block.
- Error classification:
  - a sub-block found only in the other-RD column sets rx_rd_err=1 and rx_cv=0; the octet is still decoded;
  - a sub-block found in neither column sets rx_cv=1, rx_o_set=8'h00, rx_k=0;
  - rx_cv and rx_rd_err are never both 1.
- rx_comma depends only on bits a..g. It is independent of the error flags.
- Cycles with rx_valid=0: dec_valid=0; rx_o_set, rx_k, rx_comma, rx_cv, rx_rd_err and RD all hold.

## Timing
- Latency: group sampled at edge N with rx_valid=1 → all outputs and RD reflect it after edge N. dec_valid is high for exactly the cycle following edge N.
- Back-to-back rx_valid=1 gives full throughput, one group per clock. RD chains across consecutive groups with no bubble.
- Reset values, applied immediately when mr_main_reset=0 (also mid-stream): dec_valid=0, rx_o_set=0, rx_k=0, rx_comma=0, rx_cv=0, rx_rd_err=0, rx_rd=0, err_cnt=0.
- First valid group after reset release is decoded against RD negative.

## Configuration
- DECODER_ERR_CNT_EN defined:
  - err_cnt exists;
  - increments by 1 at each sampled group with rx_cv or rx_rd_err;
  - saturates at 255;
  - clears only on reset.
- Not defined: err_cnt port and its register are absent. All other behaviour is identical.

## Test plan
- Reset asserted mid-stream → all outputs zero immediately. After release, first group is checked against RD-.
- RD-, rx_code_group=10'b1010101010 (D21.5) → rx_o_set=8'hB5, rx_k=0, no errors, rx_rd stays 0.
- RD-, 10'b0011111010 (K28.5) → 8'hBC, rx_k=1, rx_comma=1, rx_rd=1. Next 10'b1100000101 → 8'hBC, rx_k=1, rx_rd=0, no errors.
- RD-, 10'b1100000101 → rx_rd_err=1, rx_cv=0, rx_o_set=8'hBC, rx_rd stays 0. err_cnt=1 when the macro is enabled.
- 10'b0000000000 → rx_cv=1, rx_o_set=8'h00, rx_k=0. With the macro, 300 such groups leave err_cnt=255.
- rx_valid pulsed with idle gaps between D0.0 groups (10'b1001110100 at RD-) → dec_valid only on the cycle after each valid. Outputs and RD hold across the gaps.
